// File: rtl/keccak_absorb_sipo_if.sv
// Stream interface for the Keccak absorb block assembler: message word input and
// rate-sized block output, both valid/ready.
interface keccak_absorb_sipo_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 17
);
  localparam int unsigned BW = $clog2(WIDTH / 8 + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     in_last;
  logic [BW-1:0]            in_bytes;
  logic                     out_valid;
  logic                     out_ready;
  logic [DEPTH*WIDTH-1:0]   out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/keccak_absorb_sipo.sv
// Collects WIDTH-bit message words into one DEPTH-word rate block, applies Keccak
// multi-rate padding on the final word and hands the block on over valid/ready.
module keccak_absorb_sipo #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 17,
  parameter bit          PAD_EN   = 1'b1,
  parameter logic [7:0]  PAD_BYTE = 8'h06
) (
  input logic                 clk,
  input logic                 rst,
  keccak_absorb_sipo_if.slave bus
);
  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LastIdx = CW'(DEPTH - 1);

  typedef enum logic [1:0] {StFill, StPad, StHold} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         pp_q, pp_d;
  logic                         last_q, last_d;
  logic [PW-1:0]                zfrom_q, zfrom_d;   // first word to clear in PAD
  logic                         padb_q, padb_d;     // PAD_BYTE goes to byte 0 of zfrom_q
  logic                         in_ready_q, out_valid_q;
  logic [DEPTH-1:0][WIDTH-1:0]  buf_q, buf_d;
  logic [WIDTH-1:0]             word_in;
  int unsigned                  nbytes;

  // Incoming word with the tail bytes of a final word masked and the domain byte placed.
  always_comb begin
    word_in = '0;
    nbytes  = NB;
    if (bus.in_last) begin
      nbytes = 32'(bus.in_bytes);
      if (nbytes > NB) nbytes = NB;
    end
    for (int unsigned k = 0; k < NB; k++) begin
      if (k < nbytes) begin
        word_in[8*k +: 8] = bus.in_data[8*k +: 8];
      end else if (PAD_EN && k == nbytes) begin
        word_in[8*k +: 8] = PAD_BYTE;
      end else begin
        word_in[8*k +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pp_d    = pp_q;
    last_d  = last_q;
    zfrom_d = zfrom_q;
    padb_d  = padb_q;
    buf_d   = buf_q;

    case (state_q)
      StFill: begin
        if (bus.in_valid && in_ready_q) begin
          buf_d[cnt_q] = word_in;
          if (!bus.in_last) begin
            if (cnt_q == LastIdx) begin
              state_d = StHold;
              last_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            zfrom_d = PW'(cnt_q) + PW'(1);
            padb_d  = (nbytes == NB);
            // A full final word in the top slot leaves no room: pad in a block of its own.
            if (PAD_EN && nbytes == NB && cnt_q == LastIdx) begin
              state_d = StHold;
              last_d  = 1'b0;
              pp_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = StPad;
            end
          end
        end
      end

      StPad: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (i >= 32'(zfrom_q)) begin
            buf_d[i] = '0;
            if (PAD_EN && padb_q && i == 32'(zfrom_q)) buf_d[i][7:0] = PAD_BYTE;
          end
        end
        if (PAD_EN) buf_d[DEPTH-1][WIDTH-1 -: 8] = buf_d[DEPTH-1][WIDTH-1 -: 8] | 8'h80;
        state_d = StHold;
        last_d  = 1'b1;
        cnt_d   = '0;
      end

      StHold: begin
        if (bus.out_ready) begin
          if (pp_q) begin
            pp_d    = 1'b0;
            buf_d   = '0;
            zfrom_d = '0;
            padb_d  = 1'b1;
            state_d = StPad;
          end else begin
            state_d = StFill;
          end
        end
      end

      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFill;
      cnt_q       <= '0;
      pp_q        <= 1'b0;
      last_q      <= 1'b0;
      zfrom_q     <= '0;
      padb_q      <= 1'b0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pp_q        <= pp_d;
      last_q      <= last_d;
      zfrom_q     <= zfrom_d;
      padb_q      <= padb_d;
      buf_q       <= buf_d;
      in_ready_q  <= (state_d == StFill);
      out_valid_q <= (state_d == StHold);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = buf_q;
  assign bus.out_last  = last_q;
endmodule
